sprite_motion_ctrl: RTL

SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

---
 rtl/sprite_motion_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous sprite position controller: manual placement from switches or
// automatic diagonal bounce, updated only on the edge that marks frame end.
module sprite_motion_ctrl #(
  parameter int HMAX    = 799,
  parameter int VMAX    = 520,
  parameter int COL_MAX = 15,
  parameter int ROW_MAX = 13
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic [7:0] sw,
  input  logic       mode,
  input  logic       pause,
  input  logic [1:0] speed,
  output logic [7:0] pos,
  output logic       frame_tick,
  output logic [1:0] dir,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_MANUAL = 2'b00,
    ST_AUTO   = 2'b01,
    ST_PAUSED = 2'b10
  } state_e;

  localparam logic [9:0] HMAX_L = 10'(HMAX);
  localparam logic [9:0] VMAX_L = 10'(VMAX);
  localparam logic [3:0] COL_L  = 4'(COL_MAX);
  localparam logic [3:0] ROW_L  = 4'(ROW_MAX);

  state_e     state_q, state_d;
  logic [3:0] row_q, row_d, col_q, col_d;
  logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [7:0] cnt_q, cnt_d;
  logic       tick_q;

  logic       tick_hit;
  logic [7:0] limit;
  logic [3:0] sw_row, sw_col;
  logic [4:0] col_step, row_step;

  // Returns {new_dir, new_coord}; an edge reflects in the same step so the coordinate
  // never leaves 0..vmax and never wraps.
  function automatic logic [4:0] bounce_step(input logic [3:0] v, input logic up,
                                             input logic [3:0] vmax);
    if (up) return (v == vmax) ? {1'b0, vmax - 4'd1} : {1'b1, v + 4'd1};
    else    return (v == 4'd0) ? {1'b1, 4'd1}        : {1'b0, v - 4'd1};
  endfunction

  // Exact compare: out-of-range counter values simply never match.
  assign tick_hit = (hc == HMAX_L) && (vc == VMAX_L);
  assign limit    = (8'd1 << speed) - 8'd1;
  assign sw_row   = (sw[7:4] > ROW_L) ? ROW_L : sw[7:4];
  assign sw_col   = (sw[3:0] > COL_L) ? COL_L : sw[3:0];
  assign col_step = bounce_step(col_q, dir_x_q, COL_L);
  assign row_step = bounce_step(row_q, dir_y_q, ROW_L);

  always_comb begin
    // NOTE: every next-state value defaults to hold first, so no path infers a latch.
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    cnt_d   = cnt_q;
    if (tick_hit) begin
      if (!mode) begin
        state_d = ST_MANUAL;
        row_d   = sw_row;
        col_d   = sw_col;
        dir_x_d = 1'b1;
        dir_y_d = 1'b1;
        cnt_d   = 8'd0;
      end else if (pause) begin
        state_d = ST_PAUSED;
      end else begin
        state_d = ST_AUTO;
        // Entering AUTO (from MANUAL or PAUSED) holds position and count for that tick.
        if (state_q == ST_AUTO) begin
          if (cnt_q >= limit) begin
            {dir_x_d, col_d} = col_step;
            {dir_y_d, row_d} = row_step;
            cnt_d            = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments; clr acts without a clock edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_MANUAL;
      row_q   <= 4'd0;
      col_q   <= 4'd0;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
      cnt_q   <= 8'd0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_hit;
    end
  end

  assign pos        = {row_q, col_q};
  assign dir        = {dir_y_q, dir_x_q};
  assign state      = state_q;
  assign frame_tick = tick_q;

endmodule
